// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller for LSB loads/stores and icache fetches (1-cycle RAM read latency).
// Optional MEM_CTRL_IO_STALL_EN: stores to addr[17:16]==2'b11 wait while io_buffer_full is high.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        lsb_to_mc_enable,
  input  logic        lsb_to_mc_wr,
  input  logic [1:0]  lsb_to_mc_ls_type,
  input  logic [31:0] lsb_to_mc_addr,
  input  logic [31:0] lsb_to_mc_st_val,
  output logic        mc_to_lsb_ld_done,
  output logic        mc_to_lsb_st_done,
  output logic [31:0] mc_to_lsb_ld_val,
  input  logic        ic_to_mc_enable,
  input  logic [31:0] ic_to_mc_addr,
  output logic        mc_to_ic_done,
  output logic [31:0] mc_to_ic_data
);

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_len;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_buf;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;
  logic        r_ld_done;
  logic        r_st_done;
  logic        r_ic_done;
  logic [31:0] r_ld_val;
  logic [31:0] r_ic_data;

  logic [2:0]  w_len;
  logic [1:0]  w_bidx;
  logic [31:0] w_merged;
  logic [31:0] w_next_a;
  logic        w_stall;

  always_comb begin
    w_len = 3'd4;
    case (lsb_to_mc_ls_type)
      2'd0:    w_len = 3'd1;
      2'd1:    w_len = 3'd2;
      default: w_len = 3'd4;
    endcase
  end

  // Byte arriving now belongs to the address issued one edge earlier.
  assign w_bidx   = r_cnt[1:0] - 2'd1;
  assign w_merged = r_buf | ({24'd0, mem_din} << {w_bidx, 3'b000});
  assign w_next_a = r_addr + {29'd0, r_cnt} + 32'd1;

`ifdef MEM_CTRL_IO_STALL_EN
  assign w_stall = (r_state == STORE) && (r_addr[17:16] == 2'b11) && io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = io_buffer_full;
  assign w_stall     = 1'b0;
`endif

  assign mem_a             = r_mem_a;
  assign mem_dout          = r_mem_dout;
  assign mem_wr            = r_mem_wr & ~w_stall;
  assign mc_to_lsb_ld_done = r_ld_done;
  assign mc_to_lsb_st_done = r_st_done;
  assign mc_to_lsb_ld_val  = r_ld_val;
  assign mc_to_ic_done     = r_ic_done;
  assign mc_to_ic_data     = r_ic_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_buf      <= '0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_mem_wr   <= 1'b0;
      r_ld_done  <= 1'b0;
      r_st_done  <= 1'b0;
      r_ic_done  <= 1'b0;
      r_ld_val   <= '0;
      r_ic_data  <= '0;
    end else if (rdy) begin
      r_ld_done <= 1'b0;
      r_st_done <= 1'b0;
      r_ic_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!clr && lsb_to_mc_enable) begin
            r_addr  <= lsb_to_mc_addr;
            r_len   <= w_len;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_mem_a <= lsb_to_mc_addr;
            if (lsb_to_mc_wr) begin
              r_state    <= STORE;
              r_mem_wr   <= 1'b1;
              r_mem_dout <= lsb_to_mc_st_val[7:0];
              r_sdata    <= {8'd0, lsb_to_mc_st_val[31:8]};
            end else begin
              r_state <= LOAD;
            end
          end else if (!clr && ic_to_mc_enable) begin
            r_state <= IFETCH;
            r_addr  <= ic_to_mc_addr;
            r_len   <= 3'd4;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_mem_a <= ic_to_mc_addr;
          end
        end
        IFETCH, LOAD: begin
          if (clr) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mem_a    <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_dout <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt != 3'd0)
              r_buf <= w_merged;
            if ((r_cnt + 3'd1) < r_len)
              r_mem_a <= w_next_a;
            else
              r_mem_a <= '0;
            if (r_cnt == r_len) begin
              r_state <= IDLE;
              r_cnt   <= '0;
              if (r_state == LOAD) begin
                r_ld_done <= 1'b1;
                r_ld_val  <= w_merged;
              end else begin
                r_ic_done <= 1'b1;
                r_ic_data <= w_merged;
              end
            end
          end
        end
        STORE: begin
          if (!w_stall) begin
            if ((r_cnt + 3'd1) < r_len) begin
              r_cnt      <= r_cnt + 3'd1;
              r_mem_a    <= w_next_a;
              r_mem_dout <= r_sdata[7:0];
              r_sdata    <= {8'd0, r_sdata[31:8]};
            end else begin
              r_state    <= IDLE;
              r_cnt      <= '0;
              r_mem_a    <= '0;
              r_mem_dout <= '0;
              r_mem_wr   <= 1'b0;
              r_st_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl; RAM model returns ((a[7:0]+1)*8'h11) one cycle after the address.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        clr = 1'b0;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        lsb_to_mc_enable = 1'b0;
  logic        lsb_to_mc_wr = 1'b0;
  logic [1:0]  lsb_to_mc_ls_type = 2'd0;
  logic [31:0] lsb_to_mc_addr = 32'd0;
  logic [31:0] lsb_to_mc_st_val = 32'd0;
  logic        mc_to_lsb_ld_done;
  logic        mc_to_lsb_st_done;
  logic [31:0] mc_to_lsb_ld_val;
  logic        ic_to_mc_enable = 1'b0;
  logic [31:0] ic_to_mc_addr = 32'd0;
  logic        mc_to_ic_done;
  logic [31:0] mc_to_ic_data;

  int n_checks = 0;
  int n_errors = 0;

  mem_ctrl u_dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .clr               (clr),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full),
    .lsb_to_mc_enable  (lsb_to_mc_enable),
    .lsb_to_mc_wr      (lsb_to_mc_wr),
    .lsb_to_mc_ls_type (lsb_to_mc_ls_type),
    .lsb_to_mc_addr    (lsb_to_mc_addr),
    .lsb_to_mc_st_val  (lsb_to_mc_st_val),
    .mc_to_lsb_ld_done (mc_to_lsb_ld_done),
    .mc_to_lsb_st_done (mc_to_lsb_st_done),
    .mc_to_lsb_ld_val  (mc_to_lsb_ld_val),
    .ic_to_mc_enable   (ic_to_mc_enable),
    .ic_to_mc_addr     (ic_to_mc_addr),
    .mc_to_ic_done     (mc_to_ic_done),
    .mc_to_ic_data     (mc_to_ic_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [7:0] t;
    t = a[7:0] + 8'd1;
    return t * 8'h11;
  endfunction

  // Synchronous-read RAM that stalls with the rest of the system.
  always @(posedge clk) if (rdy) mem_din <= ram_byte(mem_a);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lsb_req(input logic wr, input logic [1:0] ty, input logic [31:0] a, input logic [31:0] v);
    lsb_to_mc_enable  = 1'b1;
    lsb_to_mc_wr      = wr;
    lsb_to_mc_ls_type = ty;
    lsb_to_mc_addr    = a;
    lsb_to_mc_st_val  = v;
    tick();
    lsb_to_mc_enable  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] sw_val;
    logic        seen;
    sw_val = 32'hCAFEBABE;

    // Reset state
    tick();
    tick();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_ld_done", {31'd0, mc_to_lsb_ld_done}, 32'd0);
    check("rst_st_done", {31'd0, mc_to_lsb_st_done}, 32'd0);
    check("rst_ic_done", {31'd0, mc_to_ic_done}, 32'd0);
    check("rst_ld_val", mc_to_lsb_ld_val, 32'd0);
    check("rst_ic_data", mc_to_ic_data, 32'd0);
    rst = 1'b1;
    tick();

    // LW 0x100: bytes 11 22 33 44
    lsb_req(1'b0, 2'd2, 32'h100, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      check("lw_mem_a", mem_a, 32'h100 + k - 1);
      check("lw_mem_wr", {31'd0, mem_wr}, 32'd0);
      check("lw_early_done", {31'd0, mc_to_lsb_ld_done}, 32'd0);
      tick();
    end
    check("lw_done_e4", {31'd0, mc_to_lsb_ld_done}, 32'd0);
    check("lw_idle_a", mem_a, 32'd0);
    tick();
    check("lw_done_e5", {31'd0, mc_to_lsb_ld_done}, 32'd1);
    check("lw_val", mc_to_lsb_ld_val, 32'h44332211);
    tick();
    check("lw_done_pulse", {31'd0, mc_to_lsb_ld_done}, 32'd0);
    check("lw_val_held", mc_to_lsb_ld_val, 32'h44332211);

    // SB 0x203 of 0xDEADBEEF
    lsb_req(1'b1, 2'd0, 32'h203, 32'hDEADBEEF);
    check("sb_mem_a", mem_a, 32'h203);
    check("sb_dout", {24'd0, mem_dout}, 32'hEF);
    check("sb_wr", {31'd0, mem_wr}, 32'd1);
    check("sb_done_early", {31'd0, mc_to_lsb_st_done}, 32'd0);
    tick();
    check("sb_done", {31'd0, mc_to_lsb_st_done}, 32'd1);
    check("sb_wr_off", {31'd0, mem_wr}, 32'd0);
    check("sb_idle_dout", {24'd0, mem_dout}, 32'd0);
    tick();
    check("sb_done_pulse", {31'd0, mc_to_lsb_st_done}, 32'd0);

    // LH 0x102: zero-filled upper bytes
    lsb_req(1'b0, 2'd1, 32'h102, 32'h0);
    tick();
    tick();
    tick();
    check("lh_done", {31'd0, mc_to_lsb_ld_done}, 32'd1);
    check("lh_val", mc_to_lsb_ld_val, 32'h00004433);

    // LSB and icache together: LB first, then IFETCH one edge after ld_done
    ic_to_mc_enable = 1'b1;
    ic_to_mc_addr   = 32'h40;
    lsb_req(1'b0, 2'd0, 32'h100, 32'h0);
    check("prio_lsb_a", mem_a, 32'h100);
    tick();
    tick();
    check("prio_ld_done", {31'd0, mc_to_lsb_ld_done}, 32'd1);
    check("prio_ld_val", mc_to_lsb_ld_val, 32'h00000011);
    check("prio_ic_not_done", {31'd0, mc_to_ic_done}, 32'd0);
    tick();
    ic_to_mc_enable = 1'b0;
    check("prio_ic_a0", mem_a, 32'h40);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("prio_ic_a", mem_a, 32'h40 + k - 1);
    end
    tick();
    check("prio_ic_early", {31'd0, mc_to_ic_done}, 32'd0);
    tick();
    check("prio_ic_done", {31'd0, mc_to_ic_done}, 32'd1);
    check("prio_ic_data", mc_to_ic_data, 32'h84736251);
    tick();

    // clr two cycles into IFETCH
    ic_to_mc_enable = 1'b1;
    ic_to_mc_addr   = 32'h80;
    tick();
    ic_to_mc_enable = 1'b0;
    tick();
    check("clr_if_a", mem_a, 32'h81);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_if_wr", {31'd0, mem_wr}, 32'd0);
    check("clr_if_a_idle", mem_a, 32'd0);
    check("clr_if_data_held", mc_to_ic_data, 32'h84736251);
    seen = mc_to_ic_done;
    lsb_req(1'b0, 2'd0, 32'h101, 32'h0);
    seen = seen | mc_to_ic_done;
    check("clr_if_idle_accept", mem_a, 32'h101);
    tick();
    seen = seen | mc_to_ic_done;
    tick();
    seen = seen | mc_to_ic_done;
    check("clr_if_no_done", {31'd0, seen}, 32'd0);
    check("clr_lb_val", mc_to_lsb_ld_val, 32'h00000022);
    tick();

    // clr during SW 0xCAFEBABE has no effect
    lsb_req(1'b1, 2'd2, 32'h300, sw_val);
    for (int k = 1; k <= 4; k++) begin
      clr = (k == 2);
      check("sw_mem_a", mem_a, 32'h300 + k - 1);
      check("sw_dout", {24'd0, mem_dout}, {24'd0, sw_val[8*(k-1) +: 8]});
      check("sw_wr", {31'd0, mem_wr}, 32'd1);
      tick();
    end
    clr = 1'b0;
    check("sw_done", {31'd0, mc_to_lsb_st_done}, 32'd1);
    check("sw_wr_off", {31'd0, mem_wr}, 32'd0);
    tick();

    // clr in IDLE blocks acceptance for that cycle
    clr = 1'b1;
    lsb_to_mc_enable  = 1'b1;
    lsb_to_mc_wr      = 1'b1;
    lsb_to_mc_ls_type = 2'd0;
    lsb_to_mc_addr    = 32'h205;
    lsb_to_mc_st_val  = 32'h12;
    tick();
    check("clr_idle_blk_a", mem_a, 32'd0);
    check("clr_idle_blk_wr", {31'd0, mem_wr}, 32'd0);
    clr = 1'b0;
    tick();
    lsb_to_mc_enable = 1'b0;
    check("clr_idle_acc_a", mem_a, 32'h205);
    check("clr_idle_acc_dout", {24'd0, mem_dout}, 32'h12);
    tick();
    check("clr_idle_st_done", {31'd0, mc_to_lsb_st_done}, 32'd1);
    tick();

    // rdy=0 freezes a word load
    lsb_req(1'b0, 2'd2, 32'h100, 32'h0);
    tick();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rdy_hold_a", mem_a, 32'h101);
      check("rdy_hold_done", {31'd0, mc_to_lsb_ld_done}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    check("rdy_resume_a", mem_a, 32'h102);
    tick();
    tick();
    check("rdy_not_yet", {31'd0, mc_to_lsb_ld_done}, 32'd0);
    tick();
    check("rdy_done", {31'd0, mc_to_lsb_ld_done}, 32'd1);
    check("rdy_val", mc_to_lsb_ld_val, 32'h44332211);
    tick();

    // Address wrap past 0xFFFFFFFF
    lsb_req(1'b0, 2'd2, 32'hFFFFFFFE, 32'h0);
    check("wrap_a1", mem_a, 32'hFFFFFFFE);
    tick();
    check("wrap_a2", mem_a, 32'hFFFFFFFF);
    tick();
    check("wrap_a3", mem_a, 32'h00000000);
    tick();
    check("wrap_a4", mem_a, 32'h00000001);
    tick();
    tick();
    check("wrap_done", {31'd0, mc_to_lsb_ld_done}, 32'd1);
    check("wrap_val", mc_to_lsb_ld_val, 32'h221100EF);
    tick();

    // IO stall: SB 0x00030000 with io_buffer_full for 3 cycles
    lsb_req(1'b1, 2'd0, 32'h00030000, 32'h5A);
    io_buffer_full = 1'b1;
`ifdef MEM_CTRL_IO_STALL_EN
    for (int k = 0; k < 3; k++) begin
      check("io_stall_wr", {31'd0, mem_wr}, 32'd0);
      check("io_stall_done", {31'd0, mc_to_lsb_st_done}, 32'd0);
      tick();
    end
    io_buffer_full = 1'b0;
    check("io_late_wr", {31'd0, mem_wr}, 32'd1);
    check("io_late_a", mem_a, 32'h00030000);
    check("io_late_dout", {24'd0, mem_dout}, 32'h5A);
    tick();
    check("io_late_done", {31'd0, mc_to_lsb_st_done}, 32'd1);
`else
    check("io_ign_wr", {31'd0, mem_wr}, 32'd1);
    check("io_ign_dout", {24'd0, mem_dout}, 32'h5A);
    tick();
    check("io_ign_done", {31'd0, mc_to_lsb_st_done}, 32'd1);
    io_buffer_full = 1'b0;
`endif
    tick();

    // Asynchronous reset mid-load discards the transfer
    lsb_req(1'b0, 2'd2, 32'h100, 32'h0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_mem_a", mem_a, 32'd0);
    check("arst_ld_val", mc_to_lsb_ld_val, 32'd0);
    check("arst_ic_data", mc_to_ic_data, 32'd0);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | mc_to_lsb_ld_done;
    end
    check("arst_no_done", {31'd0, seen}, 32'd0);
    check("arst_idle_a", mem_a, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
